inst_buffer: RTL and testbench
==============================

# inst_buffer

Instruction queue between the instruction fetch unit (`ifu`) and the decode stage. It captures each fetched instruction word with its address, buffers up to `DEPTH` entries, and presents them in order to decode through a valid/ready handshake. Fetch keeps running while decode is paused. A flush, issued on a taken jump or redirect, discards every buffered entry in one cycle. While the queue is empty, the output is a canonical NOP so decode never sees stale data.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; a power of two, at least 2.
- `PTR_W`, 2: pointer width, equal to log2(`DEPTH`).
- `NOP`, 32'h00000013: word driven on `inst` while empty (`addi x0,x0,0`).

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `flush`  input  1  discard all entries; also blocks the current push and pop.
- `in_valid`  input  1  fetch presents a valid `in_inst`/`in_addr`.
- `in_inst`  input  `XLEN`  instruction word from `ifu`.
- `in_addr`  input  `XLEN`  address of `in_inst`.
- `in_ready`  output  1  queue accepts a push this cycle.
- `out_ready`  input  1  decode consumes the head entry this cycle; deasserted when decode pauses.
- `out_valid`  output  1  head entry is valid.
- `inst`  output  `XLEN`  head instruction, or `NOP` when empty.
- `inst_addr`  output  `XLEN`  head address, or 0 when empty.
- `count`  output  `PTR_W`+1  number of occupied entries, 0..`DEPTH`.

## Operation
- Storage is a circular buffer of `DEPTH` × (inst, addr), with a read pointer `rd_ptr`, a write pointer `wr_ptr` and an occupancy counter `cnt`.
- Push = `in_valid & in_ready & ~flush`. It writes the entry at `wr_ptr`, then `wr_ptr` increments modulo `DEPTH`.
- Pop = `out_valid & out_ready & ~flush`. Then `rd_ptr` increments modulo `DEPTH`.
- Counter update:
  - `cnt` += 1 on push only.
  - `cnt` −= 1 on pop only.
  - `cnt` is unchanged when push and pop happen in the same cycle.
- Flush sets `rd_ptr`, `wr_ptr` and `cnt` to 0 on the next edge. Storage contents are don't-care afterwards. Flush has priority over a simultaneous push and pop.
- `in_ready` = (`cnt` != `DEPTH`). It is combinational from registered state only and never depends on `out_ready`: no pass-through when full.
- `out_valid` = (`cnt` != 0).
- `inst`/`inst_addr` = entry at `rd_ptr` when `out_valid`, otherwise `NOP`/0.
- There is no bypass: an entry pushed at edge N is visible at the output after edge N.
- Pointer wrap: `DEPTH−1` → 0 with no bubble and no loss.
- Overflow is impossible because a push is gated by `in_ready`. A pop when empty is ignored because it is gated by `out_valid`.
- Reset asserted mid-operation: all state clears immediately and asynchronously; in-flight entries are lost.

## Timing
- Reset values:
  - `in_ready` = 1
  - `out_valid` = 0
  - `inst` = 32'h00000013
  - `inst_addr` = 0
  - `count` = 0
  - internal pointers = 0
- Latency from push to output is 1 cycle.
- Throughput is 1 entry per cycle in steady state, including when full: pop at N frees a slot, so `in_ready` is 1 after edge N.
- All outputs are functions of registered state; there are no combinational input-to-output paths.
- Flush asserted at edge N:
  - After N: `out_valid` = 0 and `in_ready` = 1.
  - The first post-flush push is accepted at edge N+1.

## Test plan
- **Reset/empty:** hold `rst` 2 cycles, then release → `out_valid`=0, `inst`=0x00000013, `inst_addr`=0, `in_ready`=1, `count`=0.
- **In-order fill and drain:** push (0x00500093, 0x0), (0x00100113, 0x4), (0x002081b3, 0x8) with `out_ready`=0. Check:
  - `count`=3 after the pushes.
  - Then `out_ready`=1 pops three entries in order with matching addresses.
  - Afterwards `out_valid`=0 and `inst`=NOP.
- **Full/backpressure:** with `out_ready`=0, drive `in_valid`=1 for 6 cycles → exactly 4 entries are accepted (addresses 0x0..0xC), `in_ready`=0 from the cycle after the 4th push, `count`=4. Then one pop → `in_ready`=1 on the next cycle, and the next push is accepted.
- **Simultaneous push/pop at wrap:** fill to 3, then push and pop together for 10 cycles with addresses 0x10..0x34 → `count` stays 3 and the output addresses appear strictly sequentially with no gap.
- **Flush with concurrent push/pop:** at `count`=2, assert `flush`, `in_valid` and `out_ready` together → the next cycle shows `count`=0, `out_valid`=0, and the pushed word does not appear later. A push on the following cycle appears at the output one cycle after that.
- **Async reset mid-stream:** assert `rst` between clock edges at `count`=3 → `out_valid`=0 and `count`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_buffer.sv
// Instruction queue between fetch and decode. It is a DEPTH-entry circular buffer
// with a valid/ready handshake on both sides, a single-cycle flush, and a NOP output while empty.
module inst_buffer #(
   parameter int              XLEN  = 32,
   parameter int              DEPTH = 4,
   parameter int              PTR_W = 2,
   parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [XLEN-1:0] in_inst,
   input  logic [XLEN-1:0] in_addr,
   output logic            in_ready,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_addr,
   output logic [PTR_W:0]  count
);

   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [XLEN-1:0] inst_mem [DEPTH];
   logic [XLEN-1:0] addr_mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   cnt;
   logic             push;
   logic             pop;

   // Handshake status depends only on registered occupancy, so a full queue never passes through.
   assign in_ready  = (cnt != FULL);
   assign out_valid = (cnt != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   assign inst      = out_valid ? inst_mem[rd_ptr] : NOP;
   assign inst_addr = out_valid ? addr_mem[rd_ptr] : '0;
   assign count     = cnt;

   // NOTE: storage has no reset; occupancy gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr] <= in_inst;
         addr_mem[wr_ptr] <= in_addr;
      end
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (PTR_W+1)'(1);
            2'b01:   cnt <= cnt - (PTR_W+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_buffer.sv
// Randomised and directed bench for inst_buffer, using a queue-based reference model
// and a scoreboard that a negedge monitor drains on every output handshake.
module tb_inst_buffer;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h00000013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_inst = '0;
   logic [31:0] in_addr = '0;
   logic        in_ready;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic [2:0]  count;

   int     n_cmp  = 0;
   int     n_fail = 0;
   entry_t model_q[$];
   entry_t exp_q[$];

   inst_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_inst   (in_inst),
      .in_addr   (in_addr),
      .in_ready  (in_ready),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .inst      (inst),
      .inst_addr (inst_addr),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare the visible state against the model; called just after a clock edge.
   task automatic check_status(input string tag);
      int sz = model_q.size();
      check({tag, " count"}, 32'(count), 32'(sz));
      check({tag, " out_valid"}, 32'(out_valid), 32'(sz != 0));
      check({tag, " in_ready"}, 32'(in_ready), 32'(sz != DEPTH));
      check({tag, " inst"}, inst, (sz != 0) ? model_q[0].inst : NOP);
      check({tag, " inst_addr"}, inst_addr, (sz != 0) ? model_q[0].addr : 32'h0);
   endtask

   // One clock cycle: check the state after the edge, drive the inputs, and advance the model.
   task automatic cycle(input string tag, input bit v, input bit r, input bit f,
                        input logic [31:0] i, input logic [31:0] a);
      int     sz;
      entry_t e;
      @(posedge clk);
      #1;
      check_status(tag);
      in_valid  = v;
      out_ready = r;
      flush     = f;
      in_inst   = i;
      in_addr   = a;
      sz = model_q.size();
      e  = '{inst: i, addr: a};
      if (f) begin
         model_q.delete();
         exp_q.delete();
      end else begin
         if (r && sz != 0) void'(model_q.pop_front());
         if (v && sz != DEPTH) begin
            model_q.push_back(e);
            exp_q.push_back(e);
         end
      end
   endtask

   // Monitor: every real output handshake must match the oldest outstanding push.
   initial begin
      entry_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL mon_unexpected: got %h@%h expected no output", inst, inst_addr);
            end else begin
               e = exp_q.pop_front();
               check("mon_inst", inst, e.inst);
               check("mon_addr", inst_addr, e.addr);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] words [3];
      words[0] = 32'h00500093;
      words[1] = 32'h00100113;
      words[2] = 32'h002081b3;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Fill three entries with decode paused, then drain them in order.
      for (int k = 0; k < 3; k++) cycle("fill", 1, 0, 0, words[k], 32'(4 * k));
      for (int k = 0; k < 3; k++) cycle("drain", 0, 1, 0, '0, '0);
      cycle("empty", 0, 0, 0, '0, '0);

      // Backpressure: six offered pushes, four accepted.
      for (int k = 0; k < 6; k++) cycle("full", 1, 0, 0, 32'h1000 + 32'(k), 32'(4 * k));
      cycle("full_pop", 0, 1, 0, '0, '0);
      cycle("refill", 1, 0, 0, 32'h2000, 32'h10);
      cycle("refill_chk", 0, 0, 0, '0, '0);
      for (int k = 0; k < 5; k++) cycle("drain2", 0, 1, 0, '0, '0);

      // Steady push/pop at occupancy 3 across the pointer wrap.
      for (int k = 1; k <= 3; k++) cycle("wfill", 1, 0, 0, 32'h3000 + 32'(k), 32'(4 * k));
      for (int k = 0; k < 10; k++) cycle("wrap", 1, 1, 0, 32'h4000 + 32'(k), 32'h10 + 32'(4 * k));
      cycle("wrap_end", 0, 1, 0, '0, '0);

      // Flush at count 2 with a push and a pop in the same cycle.
      cycle("pre_flush", 0, 0, 0, '0, '0);
      cycle("flush", 1, 1, 1, 32'hdeadbeef, 32'h80);
      cycle("post_flush", 1, 0, 0, 32'h5000, 32'h84);
      cycle("post_push", 0, 1, 0, '0, '0);
      cycle("post_drain", 0, 0, 0, '0, '0);

      // Asynchronous reset mid-stream at count 3.
      for (int k = 0; k < 3; k++) cycle("rfill", 1, 0, 0, 32'h6000 + 32'(k), 32'(4 * k));
      @(posedge clk);
      #1;
      check_status("pre_rst");
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst out_valid", 32'(out_valid), 32'h0);
      check("arst count", 32'(count), 32'h0);
      check("arst inst", inst, NOP);
      check("arst in_ready", 32'(in_ready), 32'h1);
      model_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;

      // Random traffic.
      for (int k = 0; k < 400; k++)
         cycle("rand", 1'($urandom_range(1)), 1'($urandom_range(1)),
               ($urandom_range(15) == 0), $urandom, $urandom);
      for (int k = 0; k < DEPTH + 1; k++) cycle("final", 0, 1, 0, '0, '0);
      cycle("final_chk", 0, 0, 0, '0, '0);

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
